// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - write-side pointer, full/almost-full flags and occupancy for an async FIFO
//
// Purpose:
//   Owns the write pointer of a dual-clock FIFO. It keeps a binary write
//   pointer, exports it Gray-coded for the read-domain synchronizer, and
//   compares it against the synchronized read pointer to produce the full
//   flag and a write-side occupancy count.
//
// Optional feature:
//   ASYNC_FIFO_AFULL_EN  defined   -> wafull registered as (next wlevel >= AFULL_THRESH)
//                        undefined -> wafull tied to 0, no threshold compare
//
// Parameters:
//   ADDR_WIDTH    memory address bits, DEPTH = 2**ADDR_WIDTH
//   AFULL_THRESH  occupancy at or above which wafull asserts (1..DEPTH)
//
// Ports:
//   wclk      in   write-domain clock
//   wrst_n    in   asynchronous active-low reset
//   winc      in   write request for the current cycle
//   wq2_rptr  in   Gray read pointer, already synchronized into wclk
//   wclken    out  memory write enable (winc & ~wfull), combinational
//   waddr     out  memory write address
//   wptr      out  registered Gray write pointer
//   wfull     out  registered full flag
//   wafull    out  registered almost-full flag
//   wlevel    out  registered write-side occupancy, 0..DEPTH

module wptr_full #(
   parameter int ADDR_WIDTH   = 8,
   parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic                  winc,
   input  logic [ADDR_WIDTH:0]   wq2_rptr,
   output logic                  wclken,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ADDR_WIDTH:0]   wptr,
   output logic                  wfull,
   output logic                  wafull,
   output logic [ADDR_WIDTH:0]   wlevel
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   // The write pointer is "full" against the read pointer when the two
   // Gray codes differ only in their top two bits.
   localparam logic [ADDR_WIDTH:0] PTR_ONE   = 1;
   localparam logic [ADDR_WIDTH:0] FULL_MASK = (PTR_ONE << ADDR_WIDTH)
                                             | (PTR_ONE << (ADDR_WIDTH - 1));

   if (ADDR_WIDTH < 1) begin : g_bad_width
      $error("wptr_full: ADDR_WIDTH must be at least 1");
   end
   if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
      $error("wptr_full: AFULL_THRESH must lie in 1..DEPTH");
   end

   logic [ADDR_WIDTH:0] wbin_q;
   logic [ADDR_WIDTH:0] wbin_d;
   logic [ADDR_WIDTH:0] wptr_q;
   logic [ADDR_WIDTH:0] wptr_d;
   logic                wfull_q;
   logic                wfull_d;
   logic [ADDR_WIDTH:0] wlevel_q;
   logic [ADDR_WIDTH:0] wlevel_d;
   logic [ADDR_WIDTH:0] rbin;
   logic                wr_en;

   // A request while full is dropped: pointer, address and enable all hold.
   assign wr_en = winc & ~wfull_q;

   always_comb begin
      wbin_d = wbin_q + {{ADDR_WIDTH{1'b0}}, wr_en};
      wptr_d = (wbin_d >> 1) ^ wbin_d;
   end

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rbin = '0;
      for (int i = 0; i <= ADDR_WIDTH; i++) begin
         rbin[i] = ^(wq2_rptr >> i);
      end
   end

   // Modular subtraction keeps the level right across pointer wrap. The read
   // pointer only lags, so a stale value can overstate occupancy but never
   // understate it.
   always_comb begin
      wlevel_d = wbin_d - rbin;
      wfull_d  = (wptr_d == (wq2_rptr ^ FULL_MASK));
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin_q   <= '0;
         wptr_q   <= '0;
         wfull_q  <= 1'b0;
         wlevel_q <= '0;
      end else begin
         wbin_q   <= wbin_d;
         wptr_q   <= wptr_d;
         wfull_q  <= wfull_d;
         wlevel_q <= wlevel_d;
      end
   end

`ifdef ASYNC_FIFO_AFULL_EN
   localparam logic [ADDR_WIDTH:0] AFULL_LVL = AFULL_THRESH[ADDR_WIDTH:0];

   logic wafull_q;
   logic wafull_d;

   assign wafull_d = (wlevel_d >= AFULL_LVL);

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wafull_q <= 1'b0;
      end else begin
         wafull_q <= wafull_d;
      end
   end

   assign wafull = wafull_q;
`else
   assign wafull = 1'b0;
`endif

   assign wclken = wr_en;
   assign waddr  = wbin_q[ADDR_WIDTH-1:0];
   assign wptr   = wptr_q;
   assign wfull  = wfull_q;
   assign wlevel = wlevel_q;

endmodule

// File: tb/tb_wptr_full.sv
// tb/tb_wptr_full.sv - self-checking bench for wptr_full (ADDR_WIDTH=2, AFULL_THRESH=3)

module tb_wptr_full;

   localparam int AW    = 2;
   localparam int DEPTH = 4;
   localparam int THR   = 3;
   localparam int MOD   = 8;
`ifdef ASYNC_FIFO_AFULL_EN
   localparam bit AFULL_EN = 1'b1;
`else
   localparam bit AFULL_EN = 1'b0;
`endif

   logic       wclk = 1'b0;
   logic       wrst_n;
   logic       winc;
   logic [2:0] wq2_rptr;
   logic       wclken;
   logic [1:0] waddr;
   logic [2:0] wptr;
   logic       wfull;
   logic       wafull;
   logic [2:0] wlevel;

   wptr_full #(.ADDR_WIDTH(AW), .AFULL_THRESH(THR)) dut (
      .wclk     (wclk),
      .wrst_n   (wrst_n),
      .winc     (winc),
      .wq2_rptr (wq2_rptr),
      .wclken   (wclken),
      .waddr    (waddr),
      .wptr     (wptr),
      .wfull    (wfull),
      .wafull   (wafull),
      .wlevel   (wlevel)
   );

   always #5 wclk = ~wclk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: count of accepted writes and visible reads, mod 2*DEPTH.
   int m_wbin;
   int m_level;
   int rb;
   bit m_full;
   bit m_afull;
   logic       exp_wclken;
   logic       act_wclken;
   logic [1:0] act_waddr;

   logic [9:0] act_vec;
   assign act_vec = {wptr, waddr, wfull, wafull, wlevel};

   function automatic logic [2:0] to_gray(input int b);
      logic [2:0] v;
      v = b[2:0];
      return v ^ (v >> 1);
   endfunction

   function automatic logic [9:0] exp_vec();
      logic [2:0] bb;
      logic [2:0] lv;
      bb = m_wbin[2:0];
      lv = m_level[2:0];
      return {to_gray(m_wbin), bb[1:0], m_full, m_afull, lv};
   endfunction

   task automatic model_reset();
      m_wbin  = 0;
      m_level = 0;
      m_full  = 1'b0;
      m_afull = 1'b0;
      rb      = 0;
   endtask

   task automatic do_reset();
      winc     = 1'b0;
      wq2_rptr = 3'b000;
      @(negedge wclk);
      wrst_n = 1'b0;
      @(negedge wclk);
      wrst_n = 1'b1;
      model_reset();
      @(posedge wclk);
      #1;
   endtask

   // One write-clock cycle: drive, sample the combinational enable, clock,
   // advance the model. Entered and left at posedge+1.
   task automatic cycle(input bit w, input int r);
      winc     = w;
      rb       = r % MOD;
      wq2_rptr = to_gray(rb);
      #1;
      exp_wclken = w && !m_full;
      act_wclken = wclken;
      act_waddr  = waddr;
      @(posedge wclk);
      if (exp_wclken) m_wbin = (m_wbin + 1) % MOD;
      m_level = (m_wbin - rb + MOD) % MOD;
      m_full  = (m_level == DEPTH);
      m_afull = AFULL_EN && (m_level >= THR);
      #1;
   endtask

   task automatic test_reset();
      wrst_n   = 1'b0;
      winc     = 1'b0;
      wq2_rptr = 3'b000;
      #1;
      n_total++;
      if (act_vec !== 10'b0) $display("FAIL reset_state: got %b want %b", act_vec, 10'b0);
      else n_pass++;
      n_total++;
      if (wclken !== 1'b0) $display("FAIL reset_wclken_lo: got %b want 0", wclken);
      else n_pass++;
      winc = 1'b1;
      #1;
      n_total++;
      if (wclken !== 1'b1) $display("FAIL reset_wclken_hi: got %b want 1", wclken);
      else n_pass++;
      winc = 1'b0;
      @(negedge wclk);
      wrst_n = 1'b1;
      model_reset();
      @(posedge wclk);
      #1;
      n_total++;
      if (act_vec !== exp_vec()) $display("FAIL post_reset_idle: got %b want %b", act_vec, exp_vec());
      else n_pass++;
   endtask

   task automatic test_fill();
      logic [2:0] ptr_seq [4];
      ptr_seq = '{3'b001, 3'b011, 3'b010, 3'b110};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 0);
         n_total++;
         if (act_waddr !== i[1:0] || act_wclken !== 1'b1)
            $display("FAIL fill_write%0d: got addr %0d en %b want addr %0d en 1", i, act_waddr, act_wclken, i);
         else n_pass++;
         n_total++;
         if (wptr !== ptr_seq[i]) $display("FAIL fill_wptr%0d: got %b want %b", i, wptr, ptr_seq[i]);
         else n_pass++;
         n_total++;
         if (act_vec !== exp_vec()) $display("FAIL fill_state%0d: got %b want %b", i, act_vec, exp_vec());
         else n_pass++;
         if (i == 2) begin
            n_total++;
            if (wlevel !== 3'd3 || wafull !== AFULL_EN || wfull !== 1'b0)
               $display("FAIL fill_afull: got lvl %0d af %b f %b want lvl 3 af %b f 0", wlevel, wafull, wfull, AFULL_EN);
            else n_pass++;
         end
         if (i == 3) begin
            n_total++;
            if (wlevel !== 3'd4 || wfull !== 1'b1)
               $display("FAIL fill_full: got lvl %0d f %b want lvl 4 f 1", wlevel, wfull);
            else n_pass++;
         end
      end
      cycle(1'b1, 0);
      n_total++;
      if (act_wclken !== 1'b0 || wptr !== 3'b110 || waddr !== 2'd0)
         $display("FAIL write_when_full: got en %b ptr %b addr %0d want en 0 ptr 110 addr 0", act_wclken, wptr, waddr);
      else n_pass++;
   endtask

   task automatic test_full_read();
      cycle(1'b1, 1);
      n_total++;
      if (act_wclken !== 1'b0 || wfull !== 1'b0 || wlevel !== 3'd3)
         $display("FAIL full_read: got en %b f %b lvl %0d want en 0 f 0 lvl 3", act_wclken, wfull, wlevel);
      else n_pass++;
      cycle(1'b1, 1);
      n_total++;
      if (act_wclken !== 1'b1 || act_waddr !== 2'd0 || wptr !== 3'b111 || wfull !== 1'b1)
         $display("FAIL refill: got en %b addr %0d ptr %b f %b want en 1 addr 0 ptr 111 f 1",
                  act_wclken, act_waddr, wptr, wfull);
      else n_pass++;
      n_total++;
      if (act_vec !== exp_vec()) $display("FAIL refill_state: got %b want %b", act_vec, exp_vec());
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic [2:0] prev;
      bit saw_wrap;
      saw_wrap = 1'b0;
      do_reset();
      prev = wptr;
      for (int wn = 0; wn < 24; wn++) begin
         cycle(1'b1, (wn < 1) ? 0 : wn - 1);
         n_total++;
         if (act_vec !== exp_vec()) $display("FAIL wrap_state%0d: got %b want %b", wn, act_vec, exp_vec());
         else n_pass++;
         n_total++;
         if ($countones(prev ^ wptr) != 1) $display("FAIL wrap_onebit%0d: got %b -> %b want one-bit change", wn, prev, wptr);
         else n_pass++;
         if (wn >= 1) begin
            n_total++;
            if (wlevel !== 3'd2 || wfull !== 1'b0)
               $display("FAIL wrap_level%0d: got lvl %0d f %b want lvl 2 f 0", wn, wlevel, wfull);
            else n_pass++;
         end
         if (prev == 3'b100 && wptr == 3'b000) saw_wrap = 1'b1;
         prev = wptr;
      end
      n_total++;
      if (!saw_wrap) $display("FAIL wrap_seen: got no 100->000 transition want one");
      else n_pass++;
   endtask

   task automatic test_reset_midburst();
      do_reset();
      cycle(1'b1, 0);
      cycle(1'b1, 0);
      winc = 1'b1;
      #2;
      wrst_n = 1'b0;
      #1;
      n_total++;
      if (act_vec !== 10'b0 || wclken !== 1'b1)
         $display("FAIL midburst_reset: got %b en %b want 0 en 1", act_vec, wclken);
      else n_pass++;
      @(posedge wclk);
      #1;
      n_total++;
      if (act_vec !== 10'b0) $display("FAIL reset_held_edge: got %b want 0", act_vec);
      else n_pass++;
      winc = 1'b0;
      @(negedge wclk);
      wrst_n = 1'b1;
      model_reset();
      @(posedge wclk);
      #1;
      cycle(1'b1, 0);
      n_total++;
      if (act_waddr !== 2'd0 || act_wclken !== 1'b1 || wptr !== 3'b001)
         $display("FAIL first_write_after_reset: got addr %0d en %b ptr %b want addr 0 en 1 ptr 001",
                  act_waddr, act_wclken, wptr);
      else n_pass++;
   endtask

   task automatic test_random();
      int r;
      bit w;
      do_reset();
      for (int k = 0; k < 300; k++) begin
         w = ($urandom_range(0, 3) != 0);
         r = rb;
         if ($urandom_range(0, 2) == 0 && r != m_wbin) r = (r + 1) % MOD;
         cycle(w, r);
         n_total++;
         if (act_wclken !== exp_wclken || act_vec !== exp_vec())
            $display("FAIL random%0d: got en %b vec %b want en %b vec %b", k, act_wclken, act_vec, exp_wclken, exp_vec());
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_read();
      test_wrap();
      test_reset_midburst();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the number of memory address bits, with DEPTH = 2^ADDR_WIDTH.
REQ-002 The block SHALL have parameter AFULL_THRESH, default 2^ADDR_WIDTH - 2, meaning the occupancy at or above which wafull asserts; legal range 1..DEPTH.
REQ-003 The block SHALL have port wclk  input  1  write-domain clock; all state updates on its rising edge.
REQ-004 The block SHALL have port wrst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port winc  input  1  write request for the current cycle.
REQ-006 The block SHALL have port wq2_rptr  input  ADDR_WIDTH+1  Gray-coded read pointer, already two-flop synchronized into wclk.
REQ-007 The block SHALL have port wclken  output  1  memory write enable, winc AND NOT wfull, combinational.
REQ-008 The block SHALL have port waddr  output  ADDR_WIDTH  memory write address, the low ADDR_WIDTH bits of the binary write pointer.
REQ-009 The block SHALL have port wptr  output  ADDR_WIDTH+1  registered Gray-coded write pointer for the read-domain synchronizer.
REQ-010 The block SHALL have port wfull  output  1  registered full flag.
REQ-011 The block SHALL have port wafull  output  1  registered almost-full flag.
REQ-012 The block SHALL have port wlevel  output  ADDR_WIDTH+1  registered write-side occupancy, range 0..DEPTH.

Function
REQ-013 The block SHALL hold a registered binary pointer wbin of ADDR_WIDTH+1 bits, and each cycle SHALL compute wbinnext = wbin + (winc AND NOT wfull), modulo 2^(ADDR_WIDTH+1).
REQ-014 The block SHALL compute wgraynext = (wbinnext >> 1) XOR wbinnext and SHALL register it into wptr each cycle, so wptr changes by at most one bit per cycle.
REQ-015 The block SHALL register wfull to 1 exactly when wgraynext equals wq2_rptr with its two MSBs inverted and its remaining bits unchanged.
REQ-016 A write request while full SHALL leave wbin, wptr and waddr unchanged and SHALL hold wclken at 0.
REQ-017 The block SHALL derive rbin by Gray-to-binary conversion of wq2_rptr, and SHALL register wlevel = wbinnext - rbin modulo 2^(ADDR_WIDTH+1).
REQ-018 Pointer wrap from 2^(ADDR_WIDTH+1)-1 to 0 SHALL be seamless; wlevel and wfull SHALL be correct across the wrap.
REQ-019 A read that becomes visible on wq2_rptr in the same cycle as a write SHALL be reflected in wlevel, wfull and wafull on the next edge; while full, this read SHALL clear wfull one cycle later.
REQ-020 Flags SHALL be pessimistic only: the synchronizer latency may delay deassertion of wfull, and wfull SHALL never be deasserted while wlevel equals DEPTH.

Reset
REQ-021 When wrst_n is low, the block SHALL immediately clear wbin, wptr, wfull, wafull and wlevel to 0, regardless of wclk.
REQ-022 Reset asserted mid-operation SHALL discard any in-flight write; the first write after reset release SHALL use waddr 0.
REQ-023 wclken SHALL be 0 during reset whenever winc is 0, and SHALL follow winc, since wfull is 0 in reset.

Configuration
REQ-024 Macro ASYNC_FIFO_AFULL_EN defined: wafull SHALL be registered as (next wlevel >= AFULL_THRESH).
REQ-025 Macro ASYNC_FIFO_AFULL_EN undefined: wafull SHALL be tied to constant 0, and no threshold compare logic SHALL be present; all other behaviour is identical.

Verification (ADDR_WIDTH=2, DEPTH=4, AFULL_THRESH=3, macro defined)
REQ-026 Reset with wrst_n=0 mid-burst -> wptr=0, waddr=0, wfull=0, wafull=0, wlevel=0 before the next wclk edge.
REQ-027 Four consecutive winc with wq2_rptr=0 -> waddr sequence 0,1,2,3; wptr sequence 001,011,010,110; wlevel=3 and wafull=1 after the third edge; wfull=1 and wlevel=4 after the fourth edge.
REQ-028 Fifth winc while full -> wclken=0; wptr stays 110; waddr stays 0.
REQ-029 With the FIFO full, set wq2_rptr=001 together with winc=1 -> no write that cycle; wfull=0 and wlevel=3 next cycle; the following winc writes waddr 0, wptr=111, and wfull=1.
REQ-030 Run 3 full wrap cycles (24 writes, read pointer trailing by 2) -> wlevel=2 throughout steady state, wptr wraps from 100 to 000 with a one-bit change, and wfull is never 1.
REQ-031 Rebuild with the macro undefined and repeat REQ-027 -> wafull=0 at all times, while all other outputs are identical.
